// File: rtl/dmtd_phavg.sv
// Per-channel DMTD phase averager. Each channel averages 2^AVGLOG phase samples
// around its first sample and tracks window spread to declare lock.
module dmtd_phavg_ch #(
  parameter int PWIDTH  = 16,
  parameter int AVGLOG  = 4,
  parameter int TOL     = 8,
  parameter int STABLEN = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              stb,
  input  logic [PWIDTH-1:0] phase,
  output logic [PWIDTH-1:0] avg,
  output logic              stb_avg,
  output logic [PWIDTH:0]   spread,
  output logic              locked
);
  localparam int AW = PWIDTH + AVGLOG;
  localparam int NW = AVGLOG + 1;
  localparam int GW = $clog2(STABLEN + 1);
  localparam logic [NW-1:0] NLAST = NW'((1 << AVGLOG) - 1);

  typedef enum logic [1:0] {IDLE, REF, ACC} state_t;
  state_t st;

  logic [PWIDTH-1:0]        ref_q;
  logic signed [AW-1:0]     acc_q;
  logic signed [PWIDTH-1:0] mn_q, mx_q;
  logic [NW-1:0]            n_q;
  logic [GW-1:0]            good_q;

  logic signed [PWIDTH-1:0] d, mn_n, mx_n;
  logic signed [AW-1:0]     acc_n;
  logic [PWIDTH-1:0]        avg_n;
  logic [PWIDTH:0]          spread_n;
  logic [GW-1:0]            good_n;

  // Deviations are taken relative to the window's first sample, so modulo
  // wrap of the phase word only matters once, when the mean is re-based.
  assign d        = phase - ref_q;
  assign acc_n    = acc_q + $signed({{AVGLOG{d[PWIDTH-1]}}, d});
  assign mn_n     = (d < mn_q) ? d : mn_q;
  assign mx_n     = (d > mx_q) ? d : mx_q;
  assign avg_n    = ref_q + PWIDTH'(acc_n >>> AVGLOG);
  assign spread_n = {mx_n[PWIDTH-1], mx_n} - {mn_n[PWIDTH-1], mn_n};
  assign good_n   = (spread_n > (PWIDTH+1)'(TOL)) ? '0 :
                    (good_q == GW'(STABLEN))      ? good_q : good_q + GW'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st      <= IDLE;
      ref_q   <= '0;
      acc_q   <= '0;
      mn_q    <= '0;
      mx_q    <= '0;
      n_q     <= '0;
      good_q  <= '0;
      avg     <= '0;
      spread  <= '0;
      stb_avg <= 1'b0;
      locked  <= 1'b0;
    end else begin
      stb_avg <= 1'b0;
      if (!enable) begin
        st     <= IDLE;
        good_q <= '0;
        locked <= 1'b0;
      end else begin
        case (st)
          IDLE: st <= REF;
          REF: if (stb) begin
            ref_q <= phase;
            acc_q <= '0;
            mn_q  <= '0;
            mx_q  <= '0;
            n_q   <= NW'(1);
            st    <= ACC;
          end
          ACC: if (stb) begin
            if (n_q == NLAST) begin
              avg     <= avg_n;
              spread  <= spread_n;
              stb_avg <= 1'b1;
              good_q  <= good_n;
              locked  <= (good_n == GW'(STABLEN));
              st      <= REF;
            end else begin
              acc_q <= acc_n;
              mn_q  <= mn_n;
              mx_q  <= mx_n;
              n_q   <= n_q + NW'(1);
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

module dmtd_phavg #(
  parameter int NCH     = 4,
  parameter int PWIDTH  = 16,
  parameter int AVGLOG  = 4,
  parameter int TOL     = 8,
  parameter int STABLEN = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic [NCH-1:0]          stb_phase,
  input  logic [NCH*PWIDTH-1:0]   phase,
  output logic [NCH*PWIDTH-1:0]   avg,
  output logic [NCH-1:0]          stb_avg,
  output logic [NCH*(PWIDTH+1)-1:0] spread,
  output logic [NCH-1:0]          locked,
  output logic                    alllocked
);
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    dmtd_phavg_ch #(
      .PWIDTH(PWIDTH), .AVGLOG(AVGLOG), .TOL(TOL), .STABLEN(STABLEN)
    ) u_ch (
      .clk     (clk),
      .rstn    (rstn),
      .enable  (enable),
      .stb     (stb_phase[k]),
      .phase   (phase[k*PWIDTH +: PWIDTH]),
      .avg     (avg[k*PWIDTH +: PWIDTH]),
      .stb_avg (stb_avg[k]),
      .spread  (spread[k*(PWIDTH+1) +: PWIDTH+1]),
      .locked  (locked[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) alllocked <= 1'b0;
    else       alllocked <= &locked;
  end
endmodule

// File: doc/dmtd_phavg.md
DMTD_PHAVG -- requirements
Module: dmtd_phavg

Interface
REQ-001 SHALL have parameter NCH, 4, number of independent phase channels.
REQ-002 SHALL have parameter PWIDTH, 16, phase word width; phase is modulo 2^PWIDTH.
REQ-003 SHALL have parameter AVGLOG, 4, log2 of samples per averaging window (N=2^AVGLOG).
REQ-004 SHALL have parameter TOL, 8, maximum allowed in-window spread (max d - min d) for a good window.
REQ-005 SHALL have parameter STABLEN, 3, consecutive good windows required for lock.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port rstn, input, 1; reset is synchronous and active-low.
REQ-008 SHALL have port enable, input, 1, global run enable.
REQ-009 SHALL have port stb_phase, input, NCH, per-channel sample strobe (DMTD stb_phaseab, already in clk domain).
REQ-010 SHALL have port phase, input, NCH*PWIDTH, per-channel sample; channel k at bits [k*PWIDTH +: PWIDTH].
REQ-011 SHALL have port avg, output, NCH*PWIDTH, per-channel window mean, same packing.
REQ-012 SHALL have port stb_avg, output, NCH, one-cycle pulse marking a new avg value.
REQ-013 SHALL have port spread, output, NCH*(PWIDTH+1), last window max d - min d, unsigned.
REQ-014 SHALL have port locked, output, NCH, per-channel stability flag.
REQ-015 SHALL have port alllocked, output, 1, registered AND of locked.

Function
REQ-016 SHALL run one independent state machine per channel: IDLE, REF, ACC.
REQ-017 SHALL go IDLE->REF when enable=1; any state->IDLE when enable=0, discarding partial window, clearing good-window count and locked, holding avg/spread.
REQ-018 SHALL in REF, on stb: store ref=phase, acc=0, n=1, min=max=0, go ACC.
REQ-019 SHALL in ACC, on stb: d = (phase-ref) mod 2^PWIDTH read as signed PWIDTH; acc += sign-extended d; min/max update with d; n += 1.
REQ-020 SHALL keep acc at PWIDTH+AVGLOG signed bits; no overflow possible.
REQ-021 SHALL on the stb giving n=N: avg <= (ref + ((acc+d) >>> AVGLOG)) mod 2^PWIDTH (arithmetic shift, floor); spread <= max-min including this d; stb_avg pulses the following cycle; state -> REF.
REQ-022 SHALL have latency exactly 1 clk from final-sample stb to avg valid with stb_avg=1.
REQ-023 SHALL accept a stb on the cycle stb_avg is high as the next window's ref (no dead cycle).
REQ-024 SHALL on window completion: spread<=TOL -> good count +1, saturating at STABLEN; else good count=0.
REQ-025 SHALL set locked=1 in the same cycle as stb_avg when good count reaches STABLEN; clear it in the same cycle as stb_avg of any bad window.
REQ-026 SHALL treat channels fully independently, including simultaneous strobes on all channels.
REQ-027 SHALL ignore stb in IDLE; stb on consecutive cycles each count as samples.
REQ-028 SHALL update alllocked one cycle after locked.

Reset
REQ-029 SHALL, while rstn=0 at a clk edge, clear avg, spread, stb_avg, locked, alllocked, good counts, accumulators to 0 and all channels to IDLE.
REQ-030 SHALL on reset mid-window discard the window; first stb after release with enable=1 is a new ref.

Verification (NCH=4, PWIDTH=16, AVGLOG=2, TOL=8, STABLEN=3)
REQ-031 SHALL check ch0 samples 100,102,98,104 -> avg=101, spread=6, stb_avg 1 cycle after 4th stb, no stb_avg earlier.
REQ-032 SHALL check wrap: ch1 samples 0xFFFE,0x0000,0x0002,0xFFFC -> avg=0xFFFF, spread=6.
REQ-033 SHALL check floor rounding: ch2 samples 10,9,9,9 -> avg=9; and simultaneous stb on all 4 channels with distinct data -> 4 correct stb_avg pulses same cycle.
REQ-034 SHALL check lock: three good windows -> locked[0] rises with 3rd stb_avg; then window 100,120,100,100 (spread 20) -> locked[0] and alllocked fall.
REQ-035 SHALL check enable drop after 2 samples -> no stb_avg, locked=0; re-enable plus 4 samples 50,50,50,50 -> avg=50.
REQ-036 SHALL check rstn=0 mid-window -> all outputs 0 next cycle; after release, 4 new samples yield a fresh correct avg.
